pixel_readout: RTL and testbench
================================

PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port convert, input, 1 bit: pixel-array FSM convert phase active.
REQ-004 The block SHALL have port read, input, 1 bit: pixel-array FSM read phase active; the array drives the pixel buses while high.
REQ-005 The block SHALL have ports pixData1..pixData4, input, 8 bits each: pixel bus values from the array.
REQ-006 The block SHALL have port ramp_code, output, 8 bits: ADC ramp code; the top level drives it onto the pixel buses while read=0.
REQ-007 The block SHALL have port out_data, output, 8 bits: streamed pixel value.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 The block SHALL have port out_last, output, 1 bit: marks pixel 4 of a frame.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, a frame was dropped.
REQ-012 The block SHALL have port short_read, output, 1 bit: sticky flag, a read phase shorter than 2 cycles occurred.
REQ-013 The block SHALL have port frame_cnt, output, 8 bits: count of fully delivered frames, wrapping.

Function
REQ-014 ramp_code SHALL increment by 1 each cycle while convert=1, saturate at 255, and load 0 in any cycle where convert=0.
REQ-015 The block SHALL register read into read_q; a capture SHALL occur at the first edge where read=1 and read_q=1 in each read phase, which allows one bus-turnaround cycle.
REQ-016 A capture SHALL store pixData1..4 as one frame into a 2-frame buffer, with exactly one capture per read phase.
REQ-017 A read phase lasting exactly 1 cycle SHALL cause no capture and SHALL set short_read.
REQ-018 A capture while both frame slots are occupied SHALL drop the new frame, SHALL leave the stored frames intact, and SHALL set overflow.
REQ-019 A capture in the same cycle as the out_last handshake SHALL be accepted, because the slot frees that cycle, and SHALL NOT set overflow.
REQ-020 The output FSM SHALL have states IDLE and SEND. IDLE goes to SEND when the buffer is non-empty. SEND stays in SEND on the last-pixel handshake if another frame is buffered, otherwise it goes to IDLE.
REQ-021 In SEND, out_valid=1 and out_data SHALL present pixels 1,2,3,4 of the oldest frame in order; the pixel index advances only on out_valid&&out_ready.
REQ-022 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 out_last SHALL equal 1 exactly while pixel 4 is presented.
REQ-024 frame_cnt SHALL increment by 1, modulo 256, on each last-pixel handshake.
REQ-025 The first pixel of a captured frame SHALL be presented on out_valid no earlier than 1 cycle after the capture edge and no later than 2 cycles after it, when the buffer was empty.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL clear the buffer, pixel index and read_q, and SHALL drive ramp_code=0, out_valid=0, out_data=0, out_last=0, overflow=0, short_read=0, frame_cnt=0 and FSM=IDLE.
REQ-028 A reset mid-stream SHALL discard any partly sent frame; after reset the block SHALL deliver no pixels from it.

Structure
REQ-029 Package pixel_readout_pkg SHALL hold N_PIX=4, PIX_W=8, N_FRAMES=2 and the output FSM state enum.
REQ-030 The frame storage SHALL be a sub-module frame_fifo: 2 entries of N_PIX*PIX_W bits, with push/pop and full/empty flags.

Verification
REQ-031 Scenario: convert high for 300 cycles -> ramp_code counts 0..255, then holds 255; convert low -> 0 on the next edge.
REQ-032 Scenario: read high for 3 cycles with pixData=0x11,0x22,0x33,0x44, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, out_last on 0x44, frame_cnt=1.
REQ-033 Scenario: as REQ-032 with out_ready toggling 1,0,1,0,... -> each value held while stalled, no pixel lost or repeated.
REQ-034 Scenario: out_ready=0 and three read phases with frames A,B,C -> overflow=1, C dropped; after releasing out_ready, A then B are delivered and frame_cnt=2.
REQ-035 Scenario: 1-cycle read pulse -> short_read=1, out_valid stays 0.
REQ-036 Scenario: reset asserted after pixel 2 of a frame is sent -> next cycle all outputs at reset values, and no further pixels from that frame.

Source files
------------

// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg
// Shared sizes, the output FSM state type and a pixel-extraction helper for
// the pixel readout block and its frame buffer.
//   N_PIX    : pixels per frame
//   PIX_W    : bits per pixel
//   N_FRAMES : frames held in the capture buffer
//   FRAME_W  : packed frame width, pixel 1 in the least significant byte
package pixel_readout_pkg;

  localparam int N_PIX    = 4;
  localparam int PIX_W    = 8;
  localparam int N_FRAMES = 2;
  localparam int FRAME_W  = N_PIX * PIX_W;
  localparam int IDX_W    = $clog2(N_PIX);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } outState_t;

  // Pixel idx (0-based) of a packed frame; pixel 1 lives in bits [PIX_W-1:0].
  function automatic logic [PIX_W-1:0] getPixel(input logic [FRAME_W-1:0] frame,
                                                input logic [IDX_W-1:0]   idx);
    return frame[idx * PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/pixel_readout_frame_fifo.sv
// frame_fifo
// Two-entry frame buffer between the capture logic and the output streamer.
// Ports:
//   clk, reset : system clock, synchronous active-high reset (empties buffer)
//   i_push     : store i_data; ignored when full unless a pop happens too
//   i_pop      : release the oldest frame; ignored when empty
//   i_data     : frame to store
//   o_head     : oldest stored frame
//   o_second   : frame behind the head (meaningful only when full)
//   o_full     : all entries occupied
//   o_empty    : no entries occupied
module frame_fifo
  import pixel_readout_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [FRAME_W-1:0] i_data,
  output logic [FRAME_W-1:0] o_head,
  output logic [FRAME_W-1:0] o_second,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PTR_W = $clog2(N_FRAMES);
  localparam int CNT_W = PTR_W + 1;

  logic [FRAME_W-1:0] r_mem [N_FRAMES];
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [CNT_W-1:0]   r_count;

  logic               w_doPush;
  logic               w_doPop;
  logic [PTR_W-1:0]   w_rdNext;
  logic [PTR_W-1:0]   w_wrNext;

  assign o_full   = (r_count == CNT_W'(N_FRAMES));
  assign o_empty  = (r_count == '0);

  // A push into a full buffer is still taken when the head leaves in the
  // same cycle; the write lands in the slot that is being freed.
  assign w_doPush = i_push && (!o_full || i_pop);
  assign w_doPop  = i_pop && !o_empty;

  assign w_rdNext = (r_rdPtr == PTR_W'(N_FRAMES - 1)) ? '0 : r_rdPtr + 1'b1;
  assign w_wrNext = (r_wrPtr == PTR_W'(N_FRAMES - 1)) ? '0 : r_wrPtr + 1'b1;

  assign o_head   = r_mem[r_rdPtr];
  assign o_second = r_mem[w_rdNext];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < N_FRAMES; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= w_wrNext;
      end
      if (w_doPop) begin
        r_rdPtr <= w_rdNext;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_readout.sv
// pixel_readout
// Generates the ADC ramp for the pixel array, captures one 4-pixel frame per
// read phase into a 2-frame buffer and streams the pixels out over a
// valid/ready interface.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   convert             : array convert phase; ramp_code counts while high
//   read                : array read phase; pixel buses valid from 2nd cycle
//   pixData1..pixData4  : pixel bus values
//   ramp_code           : ADC ramp code, saturating at 255, 0 outside convert
//   out_data/out_valid  : streamed pixel and its valid flag
//   out_ready           : downstream accepts out_data
//   out_last            : high while pixel 4 of a frame is presented
//   overflow            : sticky, a captured frame was dropped (buffer full)
//   short_read          : sticky, a read phase of a single cycle occurred
//   frame_cnt           : wrapping count of fully delivered frames
module pixel_readout
  import pixel_readout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       convert,
  input  logic       read,
  input  logic [7:0] pixData1,
  input  logic [7:0] pixData2,
  input  logic [7:0] pixData3,
  input  logic [7:0] pixData4,
  output logic [7:0] ramp_code,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       overflow,
  output logic       short_read,
  output logic [7:0] frame_cnt
);

  logic [PIX_W-1:0]   r_ramp;
  logic               r_readQ;
  logic               r_captured;
  logic               r_overflow;
  logic               r_shortRead;
  logic [7:0]         r_frameCnt;

  outState_t          r_state;
  logic [IDX_W-1:0]   r_pixIdx;
  logic               r_outValid;
  logic [PIX_W-1:0]   r_outData;
  logic               r_outLast;

  outState_t          w_stateNext;
  logic [IDX_W-1:0]   w_idxNext;
  logic               w_validNext;
  logic [PIX_W-1:0]   w_dataNext;
  logic               w_lastNext;

  logic [FRAME_W-1:0] w_frame;
  logic [FRAME_W-1:0] w_head;
  logic [FRAME_W-1:0] w_second;
  logic               w_full;
  logic               w_empty;
  logic               w_capture;
  logic               w_lastHs;
  logic               w_drop;

  assign w_frame   = {pixData4, pixData3, pixData2, pixData1};

  // The first cycle of a read phase is bus turnaround; sample on the second
  // and only once per phase.
  assign w_capture = read && r_readQ && !r_captured;
  assign w_lastHs  = r_outValid && out_ready && r_outLast;
  assign w_drop    = w_capture && w_full && !w_lastHs;

  frame_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_capture),
    .i_pop    (w_lastHs),
    .i_data   (w_frame),
    .o_head   (w_head),
    .o_second (w_second),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Ramp, read-phase tracking and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ramp      <= '0;
      r_readQ     <= 1'b0;
      r_captured  <= 1'b0;
      r_overflow  <= 1'b0;
      r_shortRead <= 1'b0;
      r_frameCnt  <= '0;
    end else begin
      if (convert) begin
        if (r_ramp != 8'hFF) begin
          r_ramp <= r_ramp + 8'd1;
        end
      end else begin
        r_ramp <= '0;
      end

      r_readQ <= read;

      if (!read) begin
        r_captured <= 1'b0;
      end else if (w_capture) begin
        r_captured <= 1'b1;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // Phase ending without ever reaching its capture cycle.
      if (!read && r_readQ && !r_captured) begin
        r_shortRead <= 1'b1;
      end

      if (w_lastHs) begin
        r_frameCnt <= r_frameCnt + 8'd1;
      end
    end
  end

  // Output FSM state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pixIdx   <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pixIdx   <= w_idxNext;
      r_outValid <= w_validNext;
      r_outData  <= w_dataNext;
      r_outLast  <= w_lastNext;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that every stream output comes straight from a flop. On the last
  // handshake the frame behind the head is the next one to stream, which is
  // why the buffer exposes its second entry.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_pixIdx;
    w_validNext = r_outValid;
    w_dataNext  = r_outData;
    w_lastNext  = r_outLast;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_stateNext = SEND;
          w_idxNext   = '0;
          w_validNext = 1'b1;
          w_dataNext  = getPixel(w_head, '0);
          w_lastNext  = 1'b0;
        end
      end
      SEND: begin
        if (r_outValid && out_ready) begin
          if (r_outLast) begin
            w_idxNext  = '0;
            w_lastNext = 1'b0;
            if (w_full) begin
              w_stateNext = SEND;
              w_validNext = 1'b1;
              w_dataNext  = getPixel(w_second, '0);
            end else begin
              w_stateNext = IDLE;
              w_validNext = 1'b0;
              w_dataNext  = '0;
            end
          end else begin
            w_idxNext  = r_pixIdx + 1'b1;
            w_dataNext = getPixel(w_head, r_pixIdx + 1'b1);
            w_lastNext = ((r_pixIdx + 1'b1) == IDX_W'(N_PIX - 1));
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign ramp_code  = r_ramp;
  assign out_data   = r_outData;
  assign out_valid  = r_outValid;
  assign out_last   = r_outLast;
  assign overflow   = r_overflow;
  assign short_read = r_shortRead;
  assign frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout
// Self-checking bench for pixel_readout. Inputs change on the falling edge;
// a reference model of the expected pixel stream (a byte queue), the ramp and
// the status flags is advanced in step with every rising edge.
module tb_pixel_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       convert;
  logic       read;
  logic [7:0] pixData1, pixData2, pixData3, pixData4;
  logic [7:0] ramp_code;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       overflow;
  logic       short_read;
  logic [7:0] frame_cnt;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state.
  logic [7:0] pixQ[$];
  int         readLen = 0;
  int         callNum = 0;
  logic       curOvf = 0, pendOvf = 0, curShort = 0, pendShort = 0;
  logic [7:0] curCnt = 0, pendCnt = 0, curRamp = 0, pendRamp = 0;
  logic       expValid, expLast, evHs, evCapture;
  logic [7:0] expData;

  pixel_readout dut (
    .clk        (clk),
    .reset      (reset),
    .convert    (convert),
    .read       (read),
    .pixData1   (pixData1),
    .pixData2   (pixData2),
    .pixData3   (pixData3),
    .pixData4   (pixData4),
    .ramp_code  (ramp_code),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .short_read (short_read),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of inputs at the falling edge and advance the model to
  // what the following rising edge should produce. exp* describe what the
  // DUT should be presenting right now, before that edge.
  task automatic applyStimulus(input logic rst, input logic conv, input logic rd,
                               input logic [31:0] pix, input logic rdy);
    @(negedge clk);
    callNum++;
    curOvf   = pendOvf;
    curShort = pendShort;
    curCnt   = pendCnt;
    curRamp  = pendRamp;
    expValid = (pixQ.size() > 0);
    expData  = expValid ? pixQ[0] : 8'h00;
    expLast  = expValid && ((pixQ.size() % 4) == 1);

    reset     = rst;
    convert   = conv;
    read      = rd;
    {pixData4, pixData3, pixData2, pixData1} = pix;
    out_ready = rdy;

    evHs      = 1'b0;
    evCapture = 1'b0;
    if (rst) begin
      pixQ.delete();
      readLen   = 0;
      pendOvf   = 1'b0;
      pendShort = 1'b0;
      pendCnt   = 8'h00;
      pendRamp  = 8'h00;
    end else begin
      pendRamp = conv ? ((curRamp == 8'hFF) ? 8'hFF : curRamp + 8'd1) : 8'h00;
      if (out_valid === 1'b1 && rdy && expValid) begin
        evHs = 1'b1;
        if (expLast) pendCnt = pendCnt + 8'd1;
        void'(pixQ.pop_front());
      end
      if (rd) begin
        readLen++;
        if (readLen == 2) begin
          evCapture = 1'b1;
          // Frames still occupying the buffer after this edge's handshake.
          if ((pixQ.size() + 3) / 4 < 2) begin
            pixQ.push_back(pix[7:0]);
            pixQ.push_back(pix[15:8]);
            pixQ.push_back(pix[23:16]);
            pixQ.push_back(pix[31:24]);
          end else begin
            pendOvf = 1'b1;
          end
        end
      end else begin
        if (readLen == 1) pendShort = 1'b1;
        readLen = 0;
      end
    end
  endtask

  task automatic test_reset;
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    nChecks++; if (ramp_code !== 8'h00) begin nErrors++; $display("[TB] FAIL reset_ramp: got %0h expected 0", ramp_code); end
    nChecks++; if (out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    nChecks++; if (out_data !== 8'h00) begin nErrors++; $display("[TB] FAIL reset_data: got %0h expected 0", out_data); end
    nChecks++; if (out_last !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_last: got %0b expected 0", out_last); end
    nChecks++; if (overflow !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
    nChecks++; if (short_read !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_short: got %0b expected 0", short_read); end
    nChecks++; if (frame_cnt !== 8'h00) begin nErrors++; $display("[TB] FAIL reset_cnt: got %0h expected 0", frame_cnt); end
  endtask

  task automatic test_ramp;
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 0);
      nChecks++;
      if (ramp_code !== curRamp) begin
        nErrors++; $display("[TB] FAIL ramp_count[%0d]: got %0d expected %0d", i, ramp_code, curRamp);
      end
    end
    nChecks++;
    if (ramp_code !== 8'hFF) begin nErrors++; $display("[TB] FAIL ramp_saturate: got %0d expected 255", ramp_code); end
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    nChecks++;
    if (ramp_code !== 8'h00) begin nErrors++; $display("[TB] FAIL ramp_clear: got %0d expected 0", ramp_code); end
  endtask

  task automatic test_single_frame;
    logic [7:0] got[$];
    int hsCall[$];
    logic [3:0] lastFlags;
    int capCall, firstValid;
    capCall = -1; firstValid = -1; lastFlags = '0;
    applyStimulus(1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 0, (i >= 1 && i <= 3), 32'h44332211, 1);
      if (out_valid === 1'b1) begin
        nChecks++;
        if (out_data !== expData || out_last !== expLast) begin
          nErrors++; $display("[TB] FAIL single_pixel: got %0h/%0b expected %0h/%0b", out_data, out_last, expData, expLast);
        end
        if (firstValid < 0) firstValid = callNum;
      end
      if (evHs) begin
        if (got.size() < 4) lastFlags[got.size()] = out_last;
        got.push_back(out_data);
        hsCall.push_back(callNum);
      end
      if (evCapture) capCall = callNum;
    end
    nChecks++;
    if (got.size() != 4 || {got[3], got[2], got[1], got[0]} !== 32'h44332211) begin
      nErrors++; $display("[TB] FAIL single_data: got %0d pixels, expected 11,22,33,44", got.size());
    end
    nChecks++;
    if (got.size() != 4 || hsCall[3] - hsCall[0] != 3) begin
      nErrors++; $display("[TB] FAIL single_consecutive: got %0d handshakes, expected 4 back-to-back", hsCall.size());
    end
    nChecks++;
    if (lastFlags !== 4'b1000) begin nErrors++; $display("[TB] FAIL single_last: got %b expected 1000", lastFlags); end
    nChecks++;
    if (firstValid - capCall < 2 || firstValid - capCall > 3) begin
      nErrors++; $display("[TB] FAIL single_latency: got %0d expected 2..3 samples", firstValid - capCall);
    end
    nChecks++;
    if (frame_cnt !== 8'd1) begin nErrors++; $display("[TB] FAIL single_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_stall;
    logic [7:0] got[$];
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, (i >= 1 && i <= 3), 32'h44332211, logic'(i % 2));
      if (out_valid === 1'b1) begin
        nChecks++;
        if (out_data !== expData || out_last !== expLast) begin
          nErrors++; $display("[TB] FAIL stall_pixel: got %0h/%0b expected %0h/%0b", out_data, out_last, expData, expLast);
        end
      end
      if (evHs) got.push_back(out_data);
    end
    nChecks++;
    if (got.size() != 4 || {got[3], got[2], got[1], got[0]} !== 32'h44332211) begin
      nErrors++; $display("[TB] FAIL stall_data: got %0d pixels, expected 11,22,33,44", got.size());
    end
    nChecks++;
    if (frame_cnt !== 8'd1) begin nErrors++; $display("[TB] FAIL stall_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_overflow;
    logic [7:0] got[$];
    logic [31:0] pix;
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 60; i++) begin
      pix = (i < 5) ? 32'hA4A3A2A1 : (i < 10) ? 32'hB4B3B2B1 : 32'hC4C3C2C1;
      applyStimulus(0, 0, ((i % 5) >= 1 && (i % 5) <= 3 && i < 15), pix, (i >= 20));
      if (out_valid === 1'b1) begin
        nChecks++;
        if (out_data !== expData || out_last !== expLast) begin
          nErrors++; $display("[TB] FAIL ovf_pixel: got %0h/%0b expected %0h/%0b", out_data, out_last, expData, expLast);
        end
      end
      if (evHs) got.push_back(out_data);
      if (i == 19) begin
        nChecks++;
        if (overflow !== 1'b1) begin nErrors++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
      end
    end
    nChecks++;
    if (got.size() != 8 || {got[3], got[2], got[1], got[0]} !== 32'hA4A3A2A1 ||
        {got[7], got[6], got[5], got[4]} !== 32'hB4B3B2B1) begin
      nErrors++; $display("[TB] FAIL ovf_order: got %0d pixels, expected A frame then B frame (8)", got.size());
    end
    nChecks++;
    if (frame_cnt !== 8'd2) begin nErrors++; $display("[TB] FAIL ovf_cnt: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_short_read;
    int sawValid;
    sawValid = 0;
    applyStimulus(1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, (i == 2), 32'h12345678, 1);
      if (out_valid !== 1'b0) sawValid++;
    end
    nChecks++;
    if (short_read !== 1'b1) begin nErrors++; $display("[TB] FAIL short_flag: got %0b expected 1", short_read); end
    nChecks++;
    if (sawValid != 0) begin nErrors++; $display("[TB] FAIL short_novalid: got %0d valid cycles expected 0", sawValid); end
  endtask

  // Last-pixel handshake of a full buffer lands on the same edge as a capture.
  task automatic test_coincident;
    logic [7:0] got[$];
    int stage;
    logic rd, rdy;
    logic [31:0] pix;
    stage = 0;
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 80; i++) begin
      rd = 1'b0; rdy = 1'b0;
      pix = (i < 5) ? 32'hD4D3D2D1 : 32'hE4E3E2E1;
      if (i < 12) begin
        rd = ((i % 5) >= 1 && (i % 5) <= 3);
      end else begin
        pix = 32'hF4F3F2F1;
        case (stage)
          0: rdy = 1'b1;
          1: begin rd = 1'b1; rdy = 1'b0; stage = 2; end
          2: begin rd = 1'b1; rdy = 1'b1; stage = 3; end
          default: rdy = 1'b1;
        endcase
      end
      applyStimulus(0, 0, rd, pix, rdy);
      if (out_valid === 1'b1) begin
        nChecks++;
        if (out_data !== expData || out_last !== expLast) begin
          nErrors++; $display("[TB] FAIL coin_pixel: got %0h/%0b expected %0h/%0b", out_data, out_last, expData, expLast);
        end
      end
      if (evHs) got.push_back(out_data);
      if (stage == 0 && i >= 12 && pixQ.size() == 5) stage = 1;
    end
    nChecks++;
    if (stage != 3) begin nErrors++; $display("[TB] FAIL coin_setup: got stage %0d expected 3", stage); end
    nChecks++;
    if (overflow !== 1'b0) begin nErrors++; $display("[TB] FAIL coin_overflow: got %0b expected 0", overflow); end
    nChecks++;
    if (got.size() != 12 || {got[11], got[10], got[9], got[8]} !== 32'hF4F3F2F1) begin
      nErrors++; $display("[TB] FAIL coin_third: got %0d pixels, expected 12 ending with frame F", got.size());
    end
    nChecks++;
    if (frame_cnt !== 8'd3) begin nErrors++; $display("[TB] FAIL coin_cnt: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_midstream_reset;
    int nHs, guard, lateValid;
    nHs = 0; guard = 0; lateValid = 0;
    applyStimulus(1, 0, 0, 32'h0, 1);
    while (nHs < 2 && guard < 30) begin
      applyStimulus(0, 1, (guard >= 1 && guard <= 3), 32'h99887766, 1);
      if (evHs) nHs++;
      guard++;
    end
    nChecks++;
    if (nHs != 2) begin nErrors++; $display("[TB] FAIL mid_setup: got %0d handshakes expected 2", nHs); end
    applyStimulus(1, 1, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    nChecks++;
    if ({ramp_code, out_data, out_valid, out_last, overflow, short_read, frame_cnt} !== 28'h0) begin
      nErrors++; $display("[TB] FAIL mid_outputs: got ramp %0h data %0h valid %0b last %0b cnt %0h expected all 0",
                          ramp_code, out_data, out_valid, out_last, frame_cnt);
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 1);
      if (out_valid !== 1'b0) lateValid++;
    end
    nChecks++;
    if (lateValid != 0) begin nErrors++; $display("[TB] FAIL mid_nopixels: got %0d valid cycles expected 0", lateValid); end
  endtask

  task automatic test_random;
    int rdLeft, gapLeft;
    logic rd;
    rdLeft = 0; gapLeft = 2;
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 840; i++) begin
      rd = 1'b0;
      if (i < 800) begin
        if (rdLeft > 0) begin rd = 1'b1; rdLeft--; end
        else if (gapLeft > 0) gapLeft--;
        else begin rdLeft = $urandom_range(1, 4); gapLeft = $urandom_range(1, 5); end
      end
      applyStimulus(0, ($urandom_range(0, 3) != 0), rd, $urandom,
                    (i >= 800) ? 1'b1 : logic'($urandom_range(0, 1)));
      nChecks++;
      if (out_valid !== 1'b0 && !expValid) begin nErrors++; $display("[TB] FAIL rnd_spurious: cycle %0d valid with nothing buffered", i); end
      if (out_valid === 1'b1 && expValid) begin
        nChecks++;
        if (out_data !== expData || out_last !== expLast) begin
          nErrors++; $display("[TB] FAIL rnd_pixel: cycle %0d got %0h/%0b expected %0h/%0b", i, out_data, out_last, expData, expLast);
        end
      end
      nChecks++;
      if ({ramp_code, overflow, short_read, frame_cnt} !== {curRamp, curOvf, curShort, curCnt}) begin
        nErrors++; $display("[TB] FAIL rnd_status: cycle %0d got ramp %0h ovf %0b short %0b cnt %0h expected %0h %0b %0b %0h",
                            i, ramp_code, overflow, short_read, frame_cnt, curRamp, curOvf, curShort, curCnt);
      end
    end
    nChecks++;
    if (pixQ.size() != 0) begin nErrors++; $display("[TB] FAIL rnd_drain: got %0d pixels undelivered expected 0", pixQ.size()); end
  endtask

  initial begin
    reset = 1'b1; convert = 1'b0; read = 1'b0; out_ready = 1'b0;
    pixData1 = 8'h00; pixData2 = 8'h00; pixData3 = 8'h00; pixData4 = 8'h00;
    $display("[TB] starting pixel_readout bench");
    test_reset();
    test_ramp();
    test_single_frame();
    test_stall();
    test_overflow();
    test_short_read();
    test_coincident();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
